// File: rtl/top_grad_eval.sv
// top_grad_eval: quartic cost f = sum (x-Tx)^4 and scaled negative-gradient steps, one shared multiplier.
// Optional build macro TOP_GRAD_STEP_CLAMP_EN clamps each step to [-1.0, +1.0] after saturation.
module top_grad_eval #(
  parameter logic [15:0] TA       = 16'h0100,
  parameter logic [15:0] TB       = 16'h0200,
  parameter logic [15:0] TC       = 16'hFF00,
  parameter logic [15:0] TD       = 16'h0300,
  parameter int          LR_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_func,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [15:0] c_in,
  input  logic [15:0] d_in,
  output logic [31:0] value,
  output logic [15:0] a_diff_out,
  output logic [15:0] b_diff_out,
  output logic [15:0] c_diff_out,
  output logic [15:0] d_diff_out,
  output logic        func_done,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MUL = 2'd2, DONE = 2'd3} state_e;

  localparam logic [15:0] TGT [4] = '{TA, TB, TC, TD};
  localparam logic signed [47:0] STEP_MAX = 48'sd32767;
  localparam logic signed [47:0] STEP_MIN = -48'sd32768;

  // Step = -(4*e3) >>> LR_SHIFT, saturated to 16 bits; bit 16 flags a saturation.
  function automatic logic [16:0] step_of(input logic signed [47:0] e3);
    logic signed [47:0] t;
    logic [15:0]        r;
    logic               ov;
    t = (48'sd0 - (e3 <<< 2)) >>> LR_SHIFT;
    if (t > STEP_MAX) begin
      r  = 16'h7FFF;
      ov = 1'b1;
    end else if (t < STEP_MIN) begin
      r  = 16'h8000;
      ov = 1'b1;
    end else begin
      r  = t[15:0];
      ov = 1'b0;
    end
`ifdef TOP_GRAD_STEP_CLAMP_EN
    if ($signed(r) > 16'sh0100) begin
      r = 16'h0100;
    end else if ($signed(r) < 16'shFF00) begin
      r = 16'hFF00;
    end else begin
      r = r;
    end
`endif
    return {ov, r};
  endfunction

  function automatic logic [32:0] sat_value(input logic [47:0] acc);
    if (acc[47:32] != 16'h0000) begin
      return {1'b1, 32'hFFFF_FFFF};
    end else begin
      return {1'b0, acc[31:0]};
    end
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        x_q [4];
  logic [15:0]        x_d [4];
  logic signed [16:0] e_q [4];
  logic signed [16:0] e_d [4];
  logic signed [47:0] e3_q [4];
  logic signed [47:0] e3_d [4];
  logic signed [47:0] e2_q, e2_d;
  logic [47:0]        acc_q, acc_d;
  logic [2:0]         var_q, var_d;
  logic [1:0]         ph_q, ph_d;
  logic [31:0]        value_q, value_d;
  logic [15:0]        diff_q [4];
  logic [15:0]        diff_d [4];
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic signed [16:0] e_sel_s;
  logic signed [47:0] e_ext_s, op_a_s, op_b_s, mul_s;
  logic signed [95:0] prod_s;

  // Shared multiplier: phase 0 -> e*e, 1 -> e2*e, 2 -> e2*e2, each floored by >>> 8.
  always_comb begin
    e_sel_s = e_q[var_q[1:0]];
    e_ext_s = {{31{e_sel_s[16]}}, e_sel_s};
    op_a_s  = 48'sd0;
    op_b_s  = 48'sd0;
    case (ph_q)
      2'd0: begin
        op_a_s = e_ext_s;
        op_b_s = e_ext_s;
      end
      2'd1: begin
        op_a_s = e2_q;
        op_b_s = e_ext_s;
      end
      2'd2: begin
        op_a_s = e2_q;
        op_b_s = e2_q;
      end
      default: begin
        op_a_s = 48'sd0;
        op_b_s = 48'sd0;
      end
    endcase
    prod_s = op_a_s * op_b_s;
    mul_s  = prod_s[55:8];
  end

  // Next-state and datapath update for IDLE -> LOAD -> MUL (12 products + finalize) -> DONE.
  always_comb begin
    logic [32:0] vsat;
    logic [16:0] st;
    logic        ov_acc;
    vsat    = 33'd0;
    st      = 17'd0;
    ov_acc  = 1'b0;
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    e3_d    = e3_q;
    e2_d    = e2_q;
    acc_d   = acc_q;
    var_d   = var_q;
    ph_d    = ph_q;
    value_d = value_q;
    diff_d  = diff_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_func) begin
          x_d[0]  = a_in;
          x_d[1]  = b_in;
          x_d[2]  = c_in;
          x_d[3]  = d_in;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        for (int i = 0; i < 4; i++) begin
          e_d[i] = $signed({x_q[i][15], x_q[i]}) - $signed({TGT[i][15], TGT[i]});
        end
        acc_d   = 48'd0;
        e2_d    = 48'sd0;
        var_d   = 3'd0;
        ph_d    = 2'd0;
        state_d = MUL;
      end
      MUL: begin
        if (var_q == 3'd4) begin
          vsat    = sat_value(acc_q);
          value_d = vsat[31:0];
          ov_acc  = vsat[32];
          for (int i = 0; i < 4; i++) begin
            st        = step_of(e3_q[i]);
            diff_d[i] = st[15:0];
            ov_acc    = ov_acc | st[16];
          end
          ovf_d   = ov_acc;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          case (ph_q)
            2'd0: begin
              e2_d = mul_s;
              ph_d = 2'd1;
            end
            2'd1: begin
              e3_d[var_q[1:0]] = mul_s;
              ph_d             = 2'd2;
            end
            2'd2: begin
              acc_d = acc_q + mul_s;
              ph_d  = 2'd0;
              var_d = var_q + 3'd1;
            end
            default: ph_d = 2'd0;
          endcase
        end
      end
      DONE: begin
        if (!start_func) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any evaluation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) begin
        x_q[i]    <= 16'h0000;
        e_q[i]    <= 17'sd0;
        e3_q[i]   <= 48'sd0;
        diff_q[i] <= 16'h0000;
      end
      e2_q    <= 48'sd0;
      acc_q   <= 48'd0;
      var_q   <= 3'd0;
      ph_q    <= 2'd0;
      value_q <= 32'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      e3_q    <= e3_d;
      diff_q  <= diff_d;
      e2_q    <= e2_d;
      acc_q   <= acc_d;
      var_q   <= var_d;
      ph_q    <= ph_d;
      value_q <= value_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value      = value_q;
  assign a_diff_out = diff_q[0];
  assign b_diff_out = diff_q[1];
  assign c_diff_out = diff_q[2];
  assign d_diff_out = diff_q[3];
  assign func_done  = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_top_grad_eval.sv
// Self-checking bench for top_grad_eval: fixed vectors, handshake, mid-run reset and random operands vs an arithmetic model.
module tb_top_grad_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_func = 1'b0;
  logic [15:0] a_in = 16'h0000, b_in = 16'h0000, c_in = 16'h0000, d_in = 16'h0000;
  logic [31:0] value;
  logic [15:0] a_diff_out, b_diff_out, c_diff_out, d_diff_out;
  logic        func_done, overflow;
  logic [3:0][15:0] dut_df;

  int total = 0;
  int bad   = 0;

  top_grad_eval dut (
    .clk(clk), .rst_n(rst_n), .start_func(start_func),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .value(value),
    .a_diff_out(a_diff_out), .b_diff_out(b_diff_out),
    .c_diff_out(c_diff_out), .d_diff_out(d_diff_out),
    .func_done(func_done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign dut_df = {d_diff_out, c_diff_out, b_diff_out, a_diff_out};

  // Reference: f and steps straight from the quartic cost using 64-bit integers.
  function automatic void model(input logic [3:0][15:0] x, output logic [31:0] v,
                                output logic [3:0][15:0] df, output logic ov);
    longint tgt [4];
    longint e, e2, e3, e4, sum, t;
    tgt = '{256, 512, -256, 768};
    sum = 0;
    ov  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e   = longint'($signed(x[i])) - tgt[i];
      e2  = (e * e) >>> 8;
      e3  = (e2 * e) >>> 8;
      e4  = (e2 * e2) >>> 8;
      sum = sum + e4;
      t   = (-(4 * e3)) >>> 4;
      if (t > 32767) begin t = 32767; ov = 1'b1; end
      else if (t < -32768) begin t = -32768; ov = 1'b1; end
`ifdef TOP_GRAD_STEP_CLAMP_EN
      if (t > 256) t = 256;
      else if (t < -256) t = -256;
`endif
      df[i] = t[15:0];
    end
    if (sum > 64'sh0000_0000_FFFF_FFFF) begin
      v  = 32'hFFFF_FFFF;
      ov = 1'b1;
    end else begin
      v = sum[31:0];
    end
  endfunction

  // Present operands, sample start once, then scramble inputs and wait (bounded) for func_done.
  task automatic run_eval(input logic [3:0][15:0] x, input bit hold, output int lat);
    @(negedge clk);
    a_in = x[0]; b_in = x[1]; c_in = x[2]; d_in = x[3];
    start_func = 1'b1;
    @(posedge clk); #1;
    start_func = hold;
    a_in = 16'($urandom); b_in = 16'($urandom); c_in = 16'($urandom); d_in = 16'($urandom);
    lat = 0;
    while (func_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (value !== 32'd0) begin bad++; $display("FAIL reset_value got=%h exp=0", value); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_df[i] !== 16'h0000) begin bad++; $display("FAIL reset_diff[%0d] got=%h exp=0", i, dut_df[i]); end
    end
    total++; if (func_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", func_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [3:0][15:0] vin [3];
    logic [3:0][15:0] vdf [3];
    logic [31:0]      vval [3];
    logic             vov [3];
    int lat;
    vin[0] = {16'h0000, 16'h0000, 16'h0000, 16'h7F00};
    vin[1] = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vin[2] = {16'h0200, 16'h0200, 16'h0200, 16'h0200};
    vval[0] = 32'hFFFF_FFFF; vov[0] = 1'b1;
    vval[1] = 32'h0000_6300; vov[1] = 1'b0;
    vval[2] = 32'h0000_5300; vov[2] = 1'b0;
`ifdef TOP_GRAD_STEP_CLAMP_EN
    vdf[0] = {16'h0100, 16'hFFC0, 16'h0100, 16'hFF00};
    vdf[1] = {16'h0100, 16'hFFC0, 16'h0100, 16'h0040};
    vdf[2] = {16'h0040, 16'hFF00, 16'h0000, 16'hFFC0};
`else
    vdf[0] = {16'h06C0, 16'hFFC0, 16'h0200, 16'h8000};
    vdf[1] = {16'h06C0, 16'hFFC0, 16'h0200, 16'h0040};
    vdf[2] = {16'h0040, 16'hF940, 16'h0000, 16'hFFC0};
`endif
    for (int k = 0; k < 3; k++) begin
      run_eval(vin[k], 1'b0, lat);
      total++; if (lat !== 14) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=14", k, lat); end
      total++; if (value !== vval[k]) begin bad++; $display("FAIL vec%0d_value got=%h exp=%h", k, value, vval[k]); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dut_df[i] !== vdf[k][i]) begin
          bad++; $display("FAIL vec%0d_diff[%0d] got=%h exp=%h", k, i, dut_df[i], vdf[k][i]);
        end
      end
      total++; if (overflow !== vov[k]) begin bad++; $display("FAIL vec%0d_ovf got=%b exp=%b", k, overflow, vov[k]); end
      @(posedge clk); #1;
      total++; if (func_done !== 1'b0) begin bad++; $display("FAIL vec%0d_done_pulse got=%b exp=0", k, func_done); end
    end
  endtask

  task automatic test_handshake();
    logic [3:0][15:0] x;
    logic [3:0][15:0] edf;
    logic [31:0] ev;
    logic eo;
    int lat;
    x = {16'h0380, 16'hFE80, 16'h0100, 16'h0040};
    model(x, ev, edf, eo);
    run_eval(x, 1'b1, lat);
    total++; if (lat !== 14) begin bad++; $display("FAIL hs_latency got=%0d exp=14", lat); end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      total++; if (func_done !== 1'b1) begin bad++; $display("FAIL hs_done_held got=%b exp=1", func_done); end
      total++; if (value !== ev) begin bad++; $display("FAIL hs_value_held got=%h exp=%h", value, ev); end
    end
    @(negedge clk);
    start_func = 1'b0;
    @(posedge clk); #1;
    total++; if (func_done !== 1'b0) begin bad++; $display("FAIL hs_done_drop got=%b exp=0", func_done); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (value !== ev) begin bad++; $display("FAIL hs_value_stable got=%h exp=%h", value, ev); end
    total++; if (dut_df !== edf) begin bad++; $display("FAIL hs_diffs_stable got=%h exp=%h", dut_df, edf); end
    total++; if (overflow !== eo) begin bad++; $display("FAIL hs_ovf_stable got=%b exp=%b", overflow, eo); end
  endtask

  task automatic test_reset_mid();
    logic [3:0][15:0] x;
    logic [3:0][15:0] edf;
    logic [31:0] ev;
    logic eo;
    int seen, lat;
    @(negedge clk);
    a_in = 16'h0000; b_in = 16'h0000; c_in = 16'h0000; d_in = 16'h0000;
    start_func = 1'b1;
    @(posedge clk); #1;
    start_func = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (value !== 32'd0) begin bad++; $display("FAIL midrst_value got=%h exp=0", value); end
    total++; if (dut_df !== 64'd0) begin bad++; $display("FAIL midrst_diffs got=%h exp=0", dut_df); end
    total++; if (func_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", func_done); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (func_done === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_discard got=%0d done cycles exp=0", seen); end
    x = {16'h0300, 16'hFF00, 16'h0200, 16'h0100};
    model(x, ev, edf, eo);
    run_eval(x, 1'b0, lat);
    total++; if (lat !== 14) begin bad++; $display("FAIL midrst_recover_lat got=%0d exp=14", lat); end
    total++; if (value !== ev) begin bad++; $display("FAIL midrst_recover_value got=%h exp=%h", value, ev); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0][15:0] x;
    logic [3:0][15:0] edf;
    logic [31:0] ev;
    logic eo;
    bit hold;
    int lat;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) x[i] = 16'($urandom);
        else x[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
      end
      hold = 1'($urandom_range(0, 1));
      model(x, ev, edf, eo);
      run_eval(x, hold, lat);
      total++; if (lat !== 14) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=14", n, lat); end
      total++; if (value !== ev) begin bad++; $display("FAIL rand%0d_value in=%h got=%h exp=%h", n, x, value, ev); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dut_df[i] !== edf[i]) begin
          bad++; $display("FAIL rand%0d_diff[%0d] in=%h got=%h exp=%h", n, i, x, dut_df[i], edf[i]);
        end
      end
      total++; if (overflow !== eo) begin bad++; $display("FAIL rand%0d_ovf in=%h got=%b exp=%b", n, x, overflow, eo); end
      @(negedge clk);
      start_func = 1'b0;
      @(posedge clk); #1;
      total++; if (func_done !== 1'b0) begin bad++; $display("FAIL rand%0d_done_drop got=%b exp=0", n, func_done); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
